// File: rtl/auth_pkg.sv
// Shared constants and types for the password entry front end and authenticator.
package auth_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned PWD_W      = 16;

   localparam logic [PWD_W-1:0] TARGET_HASH = 16'hB7E1;

   typedef enum logic [1:0] {
      S_ENTRY        = 2'd0,
      S_SUBMIT       = 2'd1,
      S_WAIT_RELEASE = 2'd2
   } entry_state_t;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus run-length debouncer for one raw push-button.
module input_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic             stable_dly_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Flip the stable level only after an unbroken run of disagreeing samples.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = ~stable_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= raw;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         cnt_q        <= cnt_d;
      end
   end

   assign level = stable_q;
   assign press = stable_q & ~stable_dly_q;

endmodule

// File: rtl/password_entry.sv
// Debounced keypad entry: collects four digits and presents them to the authenticator.
module password_entry
   import auth_pkg::entry_state_t, auth_pkg::S_ENTRY, auth_pkg::S_SUBMIT,
          auth_pkg::S_WAIT_RELEASE, auth_pkg::DIGIT_W, auth_pkg::PWD_W;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned NUM_DIGITS      = auth_pkg::NUM_DIGITS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DIGIT_W-1:0] digit_in,
   input  logic               digit_btn_raw,
   input  logic               enter_btn_raw,
   input  logic               clear_btn_raw,
   output logic [PWD_W-1:0]   password_in,
   output logic               enter_btn,
   output logic [2:0]         digit_count,
   output logic               entry_full
);

   localparam int unsigned COUNT_W = 3;

   logic enter_level, enter_press;
   logic digit_press, clear_press;
   logic unused_digit_level, unused_clear_level;

   input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
      .clk(clk), .rst(rst), .raw(enter_btn_raw), .level(enter_level), .press(enter_press)
   );
   input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_digit_db (
      .clk(clk), .rst(rst), .raw(digit_btn_raw), .level(unused_digit_level), .press(digit_press)
   );
   input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
      .clk(clk), .rst(rst), .raw(clear_btn_raw), .level(unused_clear_level), .press(clear_press)
   );

   logic [DIGIT_W-1:0] digit_meta_q, digit_sync_q;
   entry_state_t       state_q, state_d;
   logic [PWD_W-1:0]   buf_q, buf_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               enter_q, enter_d;
   logic               full_q, full_d;
   logic               full_now;

   assign full_now = (count_q == COUNT_W'(NUM_DIGITS));

   // Entry FSM; losing presses are dropped rather than queued.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      count_d = count_q;
      case (state_q)
         S_ENTRY: begin
            if (enter_press) begin
               state_d = full_now ? S_SUBMIT : S_WAIT_RELEASE;
            end else if (clear_press) begin
               buf_d   = '0;
               count_d = '0;
            end else if (digit_press && !full_now) begin
               buf_d   = {buf_q[PWD_W-DIGIT_W-1:0], digit_sync_q};
               count_d = count_q + COUNT_W'(1);
            end
         end
         S_SUBMIT: begin
            if (!enter_level) begin
               buf_d   = '0;
               count_d = '0;
               state_d = S_ENTRY;
            end
         end
         S_WAIT_RELEASE: begin
            if (!enter_level) begin
               state_d = S_ENTRY;
            end
         end
         default: state_d = S_ENTRY;
      endcase
      enter_d = (state_d == S_SUBMIT);
      full_d  = (count_d == COUNT_W'(NUM_DIGITS));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digit_meta_q <= '0;
         digit_sync_q <= '0;
         state_q      <= S_ENTRY;
         buf_q        <= '0;
         count_q      <= '0;
         enter_q      <= 1'b0;
         full_q       <= 1'b0;
      end else begin
         digit_meta_q <= digit_in;
         digit_sync_q <= digit_meta_q;
         state_q      <= state_d;
         buf_q        <= buf_d;
         count_q      <= count_d;
         enter_q      <= enter_d;
         full_q       <= full_d;
      end
   end

   assign password_in = buf_q;
   assign enter_btn   = enter_q;
   assign digit_count = count_q;
   assign entry_full  = full_q;

endmodule

// File: tb/tb_password_entry.sv
// Self-checking bench for password_entry: behavioural model plus directed and random stimulus.
module tb_password_entry;

   localparam int unsigned DB = 4;

   logic        clk;
   logic        rst;
   logic [3:0]  digit_in;
   logic        digit_btn_raw, enter_btn_raw, clear_btn_raw;
   logic [15:0] password_in;
   logic        enter_btn;
   logic [2:0]  digit_count;
   logic        entry_full;

   password_entry #(.DEBOUNCE_CYCLES(DB), .NUM_DIGITS(4)) dut (
      .clk(clk), .rst(rst), .digit_in(digit_in),
      .digit_btn_raw(digit_btn_raw), .enter_btn_raw(enter_btn_raw), .clear_btn_raw(clear_btn_raw),
      .password_in(password_in), .enter_btn(enter_btn),
      .digit_count(digit_count), .entry_full(entry_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Buttons: index 0 enter, 1 digit, 2 clear.
   bit          m_valid = 0;
   int          mode;          // 0 entry, 1 submitting, 2 waiting for enter release
   int          q[$];
   bit          hist[3][DB+2]; // hist[b][j] = raw sample taken j edges ago
   bit          lvl[3], lvl_prev[3];
   logic [3:0]  dh[2];
   logic [15:0] m_pwd;
   logic [2:0]  m_count;
   bit          m_full, m_enter;

   initial forever begin
      bit raw[3];
      bit p[3];
      bit flip;
      @(posedge clk);
      raw[0] = enter_btn_raw; raw[1] = digit_btn_raw; raw[2] = clear_btn_raw;
      if (rst) begin
         m_valid = 1;
         mode = 0;
         q.delete();
         dh[0] = '0; dh[1] = '0;
         for (int b = 0; b < 3; b++) begin
            lvl[b] = 0; lvl_prev[b] = 0;
            for (int j = 0; j < DB + 2; j++) hist[b][j] = 0;
         end
      end else begin
         for (int b = 0; b < 3; b++) p[b] = lvl[b] && !lvl_prev[b];
         case (mode)
            0: begin
               if (p[0]) mode = (q.size() == 4) ? 1 : 2;
               else if (p[2]) q.delete();
               else if (p[1] && q.size() < 4) q.push_back(int'(dh[1]));
            end
            1: if (!lvl[0]) begin q.delete(); mode = 0; end
            default: if (!lvl[0]) mode = 0;
         endcase
         dh[1] = dh[0];
         dh[0] = digit_in;
         // A level flips once DB consecutive synchronized samples all disagree with it.
         for (int b = 0; b < 3; b++) begin
            for (int j = DB + 1; j > 0; j--) hist[b][j] = hist[b][j-1];
            hist[b][0] = raw[b];
            flip = 1;
            for (int j = 2; j <= DB + 1; j++) if (hist[b][j] == lvl[b]) flip = 0;
            lvl_prev[b] = lvl[b];
            if (flip) lvl[b] = !lvl[b];
         end
      end
      m_pwd = '0;
      foreach (q[i]) m_pwd = {m_pwd[11:0], 4'(q[i])};
      m_count = 3'(q.size());
      m_full  = (q.size() == 4);
      m_enter = (mode == 1);
   end

   // Cycle-by-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         chk("password_in", 32'(password_in), 32'(m_pwd));
         chk("enter_btn", 32'(enter_btn), 32'(m_enter));
         chk("digit_count", 32'(digit_count), 32'(m_count));
         chk("entry_full", 32'(entry_full), 32'(m_full));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_digit(input logic [3:0] d);
      digit_in = d; digit_btn_raw = 1'b1;
      cyc(10);
      digit_btn_raw = 1'b0;
      cyc(10);
   endtask

   task automatic press_clear();
      clear_btn_raw = 1'b1; cyc(10);
      clear_btn_raw = 1'b0; cyc(10);
   endtask

   task automatic enter_four(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d);
      press_digit(a); press_digit(b); press_digit(c); press_digit(d);
   endtask

   initial begin
      int hi;
      int incs;
      int last_cnt;
      int waited;
      rst = 1'b1; digit_in = '0;
      digit_btn_raw = 1'b0; enter_btn_raw = 1'b0; clear_btn_raw = 1'b0;
      cyc(3);
      chk("reset_pwd", 32'(password_in), 32'h0);
      chk("reset_enter", 32'(enter_btn), 32'h0);
      chk("reset_count", 32'(digit_count), 32'h0);
      chk("reset_full", 32'(entry_full), 32'h0);
      rst = 1'b0;
      cyc(2);

      // Normal submission
      enter_four(4'h1, 4'h2, 4'h3, 4'h4);
      chk("normal_pwd", 32'(password_in), 32'h1234);
      chk("normal_count", 32'(digit_count), 32'd4);
      chk("normal_full", 32'(entry_full), 32'd1);
      hi = 0;
      for (int i = 0; i < 25; i++) begin
         enter_btn_raw = (i < 10);
         @(negedge clk);
         if (enter_btn) hi++;
      end
      chk("normal_enter_high_cycles", 32'(hi), 32'd10);
      chk("normal_after_pwd", 32'(password_in), 32'h0);
      chk("normal_after_count", 32'(digit_count), 32'd0);

      // Bounce rejection
      digit_in = 4'h5; incs = 0; last_cnt = int'(digit_count);
      for (int i = 0; i < 40; i++) begin
         digit_btn_raw = (i >= 20) ? (i < 30) : (((i / 2) % 2) == 0);
         @(negedge clk);
         if (int'(digit_count) != last_cnt) begin incs++; last_cnt = int'(digit_count); end
      end
      chk("bounce_count", 32'(digit_count), 32'd1);
      chk("bounce_transitions", 32'(incs), 32'd1);
      chk("bounce_pwd", 32'(password_in), 32'h0005);

      // Overflow
      press_clear();
      chk("clear_count", 32'(digit_count), 32'd0);
      enter_four(4'hA, 4'hB, 4'hC, 4'hD);
      press_digit(4'hE);
      chk("overflow_pwd", 32'(password_in), 32'hABCD);
      chk("overflow_count", 32'(digit_count), 32'd4);
      chk("overflow_full", 32'(entry_full), 32'd1);

      // Short entry
      press_clear();
      press_digit(4'h7); press_digit(4'h7);
      hi = 0;
      for (int i = 0; i < 25; i++) begin
         enter_btn_raw = (i < 10);
         @(negedge clk);
         if (enter_btn) hi++;
      end
      chk("short_enter_high_cycles", 32'(hi), 32'd0);
      chk("short_pwd_kept", 32'(password_in), 32'h0077);
      press_digit(4'h6); press_digit(4'h7);
      chk("short_resume_pwd", 32'(password_in), 32'h7767);

      // Clear beats a simultaneous digit press
      press_clear();
      press_digit(4'h5);
      digit_in = 4'h9; digit_btn_raw = 1'b1; clear_btn_raw = 1'b1;
      cyc(10);
      digit_btn_raw = 1'b0; clear_btn_raw = 1'b0;
      cyc(10);
      chk("priority_count", 32'(digit_count), 32'd0);
      chk("priority_pwd", 32'(password_in), 32'h0);

      // Digit presses locked out while submitting
      enter_four(4'h1, 4'h2, 4'h3, 4'h4);
      enter_btn_raw = 1'b1;
      cyc(10);
      chk("lockout_enter", 32'(enter_btn), 32'd1);
      press_digit(4'h9);
      chk("lockout_pwd", 32'(password_in), 32'h1234);
      chk("lockout_count", 32'(digit_count), 32'd4);
      enter_btn_raw = 1'b0;
      cyc(12);
      chk("lockout_release_pwd", 32'(password_in), 32'h0);

      // Reset during submission
      enter_four(4'h4, 4'h3, 4'h2, 4'h1);
      enter_btn_raw = 1'b1;
      waited = 0;
      while (!enter_btn && waited < 30) begin @(negedge clk); waited++; end
      chk("rst_submit_reached", 32'(enter_btn), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_pwd", 32'(password_in), 32'h0);
      chk("rst_mid_enter", 32'(enter_btn), 32'd0);
      chk("rst_mid_count", 32'(digit_count), 32'd0);
      chk("rst_mid_full", 32'(entry_full), 32'd0);
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (enter_btn) hi++;
      end
      chk("rst_no_reassert", 32'(hi), 32'd0);
      enter_btn_raw = 1'b0;
      cyc(12);

      // Randomized episodes
      for (int ep = 0; ep < 250; ep++) begin
         int kind;
         kind = int'($urandom_range(0, 9));
         if (kind <= 5) begin
            digit_in      = 4'($urandom);
            digit_btn_raw = ($urandom_range(0, 9) < 6);
            clear_btn_raw = ($urandom_range(0, 9) < 1);
            enter_btn_raw = ($urandom_range(0, 9) < 2);
            cyc(int'($urandom_range(6, 14)));
            digit_btn_raw = 1'b0; clear_btn_raw = 1'b0; enter_btn_raw = 1'b0;
            cyc(int'($urandom_range(6, 14)));
         end else if (kind <= 7) begin
            for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
               digit_in      = 4'($urandom);
               digit_btn_raw = 1'($urandom);
               clear_btn_raw = ($urandom_range(0, 3) == 0);
               enter_btn_raw = ($urandom_range(0, 3) == 0);
               @(negedge clk);
            end
         end else if (kind == 8) begin
            enter_btn_raw = 1'b1;
            cyc(int'($urandom_range(8, 20)));
            enter_btn_raw = 1'b0;
            cyc(int'($urandom_range(6, 12)));
         end else begin
            if ($urandom_range(0, 3) == 0) begin
               rst = 1'b1; @(negedge clk); rst = 1'b0;
            end
            cyc(2);
         end
      end
      digit_btn_raw = 1'b0; clear_btn_raw = 1'b0; enter_btn_raw = 1'b0;
      cyc(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
